// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - skewed-pipeline carry-lookahead adder/subtractor
// One CHUNK-bit slice resolved per stage; a single advance enable gives backpressure.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int NG     = CHUNK / 4;
    localparam int LAST   = STAGES - 1;

    generate
        if ((WIDTH % CHUNK) != 0 || (CHUNK % 4) != 0) begin : g_param_check
            $error("pipelined_cla_addsub: WIDTH must be a multiple of CHUNK and CHUNK a multiple of 4");
        end
    endgenerate

    // Two-level lookahead: bit carries inside each 4-bit group, group carries across the chunk.
    function automatic logic [CHUNK:0] cla_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        logic [CHUNK-1:0] g, p, bc;
        logic [NG-1:0]    gg, pg;
        logic [NG:0]      gc;
        logic             term, prod;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            pg[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
        end
        gc[0] = c;
        for (int j = 1; j <= NG; j++) begin
            term = c;
            for (int i = 0; i < j; i++) term = term & pg[i];
            for (int i = 0; i < j; i++) begin
                prod = gg[i];
                for (int m = i + 1; m < j; m++) prod = prod & pg[m];
                term = term | prod;
            end
            gc[j] = term;
        end
        for (int j = 0; j < NG; j++) begin
            bc[4*j] = gc[j];
            for (int t = 1; t < 4; t++) begin
                term = gc[j];
                for (int i = 0; i < t; i++) term = term & p[4*j+i];
                for (int i = 0; i < t; i++) begin
                    prod = g[4*j+i];
                    for (int m = i + 1; m < t; m++) prod = prod & p[4*j+m];
                    term = term | prod;
                end
                bc[4*j+t] = term;
            end
        end
        return {gc[NG], p ^ bc};
    endfunction

    logic             stg_v [STAGES];
    logic [WIDTH-1:0] stg_a [STAGES];
    logic [WIDTH-1:0] stg_b [STAGES];
    logic [WIDTH-1:0] stg_s [STAGES];
    logic             stg_c [STAGES];
    logic             ovf_q, zero_q, neg_q;

    logic             src_v [STAGES];
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];
    logic             nxt_ovf, nxt_zero, nxt_neg;
    logic             en;

    assign out_valid = stg_v[LAST];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    always_comb begin
        logic [CHUNK:0] res;
        res      = '0;
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_s[0] = '0;
        src_c[0] = cin ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = stg_v[k-1];
            src_a[k] = stg_a[k-1];
            src_b[k] = stg_b[k-1];
            src_s[k] = stg_s[k-1];
            src_c[k] = stg_c[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            res                         = cla_chunk(src_a[k][k*CHUNK +: CHUNK],
                                                    src_b[k][k*CHUNK +: CHUNK], src_c[k]);
            nxt_s[k]                    = src_s[k];
            nxt_s[k][k*CHUNK +: CHUNK]  = res[CHUNK-1:0];
            nxt_c[k]                    = res[CHUNK];
        end
        // Carry into the MSB recovered from its sum bit: a ^ b ^ s.
        nxt_ovf  = (src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ nxt_s[LAST][WIDTH-1]) ^ nxt_c[LAST];
        nxt_zero = (nxt_s[LAST] == '0);
        nxt_neg  = nxt_s[LAST][WIDTH-1];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int k = 0; k < STAGES; k++) begin
                stg_v[k] <= 1'b0;
                stg_a[k] <= '0;
                stg_b[k] <= '0;
                stg_s[k] <= '0;
                stg_c[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                stg_v[k] <= src_v[k];
                if (src_v[k]) begin
                    stg_a[k] <= src_a[k];
                    stg_b[k] <= src_b[k];
                    stg_s[k] <= nxt_s[k];
                    stg_c[k] <= nxt_c[k];
                end
            end
            if (src_v[LAST]) begin
                ovf_q  <= nxt_ovf;
                zero_q <= nxt_zero;
                neg_q  <= nxt_neg;
            end
        end
    end

    assign sum  = stg_s[LAST];
    assign cout = stg_c[LAST];
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign neg  = neg_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - directed vector bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout, ovf, zero, neg;

    int checks = 0;
    int errors = 0;

    pipelined_cla_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        logic [31:0] s;
        logic        co, ov, z, n;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] got [$];
    logic        mon_en = 1'b0;

    always @(negedge clk) if (mon_en && out_valid && out_ready) got.push_back(sum);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Offer one beat, then count edges until the result shows up (bounded).
    task automatic run_beat(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                            input logic vs, output int lat);
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          sent;
        logic        acc;
        logic [31:0] held;
        string       tag;

        vecs[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_flags", {28'd0, cout, ovf, zero, neg}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_beat(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            tag = $sformatf("v%0d", i);
            check({tag, "_latency"}, lat, 3);
            check({tag, "_sum"}, sum, vecs[i].s);
            check({tag, "_cout"}, {31'd0, cout}, {31'd0, vecs[i].co});
            check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, vecs[i].ov});
            check({tag, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].z});
            check({tag, "_neg"}, {31'd0, neg}, {31'd0, vecs[i].n});
            @(posedge clk); #1;
            check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: 8 back-to-back beats, consumer stalls for cycles 5..7
        got.delete();
        mon_en = 1'b1;
        sent = 0;
        held = '0;
        for (int c = 0; c < 60 && got.size() < 8; c++) begin
            in_valid  = (sent < 8);
            a         = sent;
            b         = sent;
            cin       = 1'b0;
            sub       = 1'b0;
            out_ready = !(c >= 5 && c < 8);
            #1;
            if (c >= 5 && c < 8) begin
                check($sformatf("bp_in_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
                if (c == 5) begin
                    check("bp_valid_at_stall", {31'd0, out_valid}, 32'd1);
                    held = sum;
                end else begin
                    check($sformatf("bp_sum_stable_c%0d", c), sum, held);
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", got.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) check($sformatf("bp_res%0d", i), got[i], 2 * i);
        end

        // Reset with three beats in flight
        got.delete();
        for (int i = 0; i < 3; i++) begin
            a = 100 + i; b = 100 + i; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        check("clr_sum", sum, 32'd0);
        check("clr_flags", {28'd0, cout, ovf, zero, neg}, 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check("clr_no_ghosts", got.size(), 0);
        mon_en = 1'b0;
        run_beat(32'd1, 32'd1, 1'b0, 1'b0, lat);
        check("post_clr_latency", lat, 3);
        check("post_clr_sum", sum, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the datapath ALU; next generation of the fixed 32-bit ripple-of-CLA adder.
- Splits WIDTH into STAGES chunks of CHUNK bits; one chunk resolved per pipeline stage with a registered carry between stages.
- Uses a valid/ready handshake with backpressure and produces carry, signed-overflow, zero and negative flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per stage; must be a multiple of 4, with one 4-bit CLA group per 4 bits and lookahead across groups inside a stage.
- STAGES (localparam), WIDTH/CHUNK, pipeline depth.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for sub.
- sub  in  1  0 = A+B+cin, 1 = A-B-cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB. For sub, 1 means no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

Behaviour:
- Operand preparation: b_eff = sub ? ~b : b; c0 = cin ^ sub.
  - sub=1, cin=0 gives A-B.
  - sub=1, cin=1 gives A-B-1.
- Global advance enable: en = !out_valid || out_ready; in_ready = en, combinational.
- A beat is accepted when in_valid && in_ready.
- Stage k (0..STAGES-1) on en:
  - adds chunk k of a/b_eff with the carry from stage k-1 (c0 for k=0);
  - registers the computed chunk plus carry;
  - carries unconsumed upper operand chunks and already-computed lower sum chunks forward (skewed pipeline).
- Each stage carries a valid bit. Bubbles advance like data, so no bubble squashing is needed.
- Latency: a beat accepted at edge N shows out_valid=1 after edge N+STAGES-1 when unstalled, i.e. STAGES register stages. Throughput is 1 beat/cycle.
- Stall: while out_valid && !out_ready, no stage register changes and outputs hold stable. in_ready=0.
- Flags are computed in the final stage from full-width values and registered with sum:
  - ovf = carry into MSB XOR cout;
  - zero = (sum == 0);
  - neg = sum MSB.
- Output registers hold their last value when out_valid=0. Consumers must qualify with out_valid.
- Reset (async, any time including mid-stream): all stage valid bits = 0, all data/flag registers = 0. out_valid=0, sum=0, cout=0, ovf=0, zero=0, neg=0. in_ready=1 once clr deasserts.
  - In-flight beats are discarded, never emitted.
- Wrap: results are modulo 2^WIDTH; no saturation.
- Simultaneous out_ready and in_valid with a full pipe: output retires and the new beat enters the same edge, with no lost or duplicated beat.
- Elaboration error if WIDTH % CHUNK != 0 or CHUNK % 4 != 0.

Test Plan:
- Single add (WIDTH=32, CHUNK=8): a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0 -> after 4 cycles sum=0x0000_0100, cout=0, ovf=0, zero=0, neg=0.
- Cross-chunk carry chain and wrap: a=0xFFFF_FFFF, b=0x1, cin=0 -> sum=0x0, cout=1, zero=1, ovf=0.
- Subtract and borrow:
  - a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0, neg=1.
  - a=7, b=5, sub=1, cin=1 -> sum=1, cout=1.
- Signed overflow: a=0x7FFF_FFFF, b=1, add -> sum=0x8000_0000, ovf=1, neg=1.
- Backpressure:
  - Stream 8 back-to-back beats (a=i, b=i) while holding out_ready=0 from cycle 5 for 3 cycles -> in_ready=0 during the stall and outputs stable.
  - After release, results 0,2,4,...,14 appear in order with none lost or duplicated.
- Reset mid-stream: assert clr with 3 beats in flight -> out_valid=0 and all outputs 0 immediately. After release those beats never appear, and a fresh beat a=1, b=1 returns 2 after 4 cycles.
